// File: rtl/onehot_ring_counter.sv
// ----------------------------------------------------------------------------
// onehot_ring_counter
//
// Parametrised one-hot ring counter with a registered binary index of the hot
// bit. Used as a phase/sequencing generator: Q drives per-stage enables and C
// provides the same phase as a binary index without an external encoder.
//
// Parameters
//   N        number of ring stages (2..256)
//   W        width of the binary index, $clog2(N); derived, leave at default
//   RST_IDX  position of the hot bit after reset (< N)
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RST       in   synchronous active-high reset
//   EN        in   advance the ring one position
//   DIR       in   0 = up (i -> i+1), 1 = down (i -> i-1), modulo N
//   LOAD      in   load position LOAD_IDX (takes priority over EN)
//   LOAD_IDX  in   position to load
//   Q         out  one-hot ring state
//   C         out  binary index of the hot bit in Q
//   WRAP      out  one-cycle pulse: the last step crossed the N-1 <-> 0 seam
//   ERR       out  one-cycle pulse: the last load requested LOAD_IDX >= N
// ----------------------------------------------------------------------------
module onehot_ring_counter #(
    parameter int N       = 16,
    parameter int W       = $clog2(N),
    parameter int RST_IDX = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         DIR,
    input  logic         LOAD,
    input  logic [W-1:0] LOAD_IDX,
    output logic [N-1:0] Q,
    output logic [W-1:0] C,
    output logic         WRAP,
    output logic         ERR
);

    localparam logic [N-1:0] ONE    = N'(1);
    localparam logic [N-1:0] RST_Q  = ONE << RST_IDX;
    localparam logic [W-1:0] RST_C  = W'(RST_IDX);
    localparam logic [W-1:0] C_LAST = W'(N - 1);
    // One extra bit so N itself is representable when N is a power of two.
    localparam logic [W:0]   N_EXT  = (W + 1)'(N);

    logic [N-1:0] q_q, q_d;
    logic [W-1:0] c_q, c_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic         load_in_range;

    // Only reachable as false when N is not a power of two.
    assign load_in_range = ({1'b0, LOAD_IDX} < N_EXT);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        q_d    = q_q;
        c_d    = c_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;

        if (LOAD) begin
            // An out-of-range load holds the ring and only raises ERR; EN is
            // ignored either way.
            if (load_in_range) begin
                q_d = ONE << LOAD_IDX;
                c_d = LOAD_IDX;
            end else begin
                err_d = 1'b1;
            end
        end else if (EN) begin
            if (!DIR) begin
                q_d = {q_q[N-2:0], q_q[N-1]};
                if (c_q == C_LAST) begin
                    c_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    c_d = c_q + W'(1);
                end
            end else begin
                q_d = {q_q[0], q_q[N-1:1]};
                if (c_q == '0) begin
                    c_d    = C_LAST;
                    wrap_d = 1'b1;
                end else begin
                    c_d = c_q - W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= RST_Q;
            c_q    <= RST_C;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            c_q    <= c_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign C    = c_q;
    assign WRAP = wrap_q;
    assign ERR  = err_q;

endmodule
